joy_dir_filter: RTL and testbench



---
 rtl/joy_dir_pkg.sv | 45 ++++
 rtl/joy_dir_filter_lane.sv | 116 +++++++++++
 rtl/joy_dir_filter.sv | 50 +++++
 tb/tb_joy_dir_filter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/joy_dir_pkg.sv
// joy_dir_pkg: shared types and helpers for the joystick direction filter.
// Build option: JOY_DEBOUNCE_EN adds per-bit input debouncing in each lane.
package joy_dir_pkg;

  typedef enum logic [1:0] {
    JM_PASS,
    JM_NEWEST,
    JM_FIRST,
    JM_SOCD
  } joy_mode_t;

  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;

  localparam logic [3:0] MASK_ALL = 4'b1111;

  // One-hot of the highest-priority set bit: up > down > left > right.
  function automatic logic [3:0] prio4(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    if (x[DIR_U])      r[DIR_U] = 1'b1;
    else if (x[DIR_D]) r[DIR_D] = 1'b1;
    else if (x[DIR_L]) r[DIR_L] = 1'b1;
    else if (x[DIR_R]) r[DIR_R] = 1'b1;
    return r;
  endfunction

  // Opposing directions cancel each other; diagonals pass.
  function automatic logic [3:0] socd4(input logic [3:0] x);
    logic [3:0] r;
    r = x;
    if (x[DIR_U] && x[DIR_D]) begin
      r[DIR_U] = 1'b0;
      r[DIR_D] = 1'b0;
    end
    if (x[DIR_L] && x[DIR_R]) begin
      r[DIR_L] = 1'b0;
      r[DIR_R] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/joy_dir_filter_lane.sv
// joy_dir_lane: one player's sampling, mask tracking and output stage.
// Build option: JOY_DEBOUNCE_EN inserts a per-bit stability filter.
module joy_dir_lane
  import joy_dir_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  joy_mode_t  i_mode,
  input  logic       i_mode_chg,
  input  logic       i_dis,
  input  logic [3:0] i_dir,
  output logic [3:0] o_dir,
  output logic       o_chg
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range");
  end

  logic [3:0] w_acc;

`ifdef JOY_DEBOUNCE_EN
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  r_acc;
  logic [15:0] r_cnt [4];

  // Accept a raw bit only once it has differed long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i_dir[i] == r_acc[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_acc[i] <= i_dir[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign w_acc = r_acc;
`else
  assign w_acc = i_dir;
`endif

  logic [3:0] r_s1, r_s2, r_mask, r_dir;
  logic       r_chg;
  logic [3:0] w_new, w_mask_nx, w_dir_nx;

  assign w_new = r_s1 & ~r_s2;

  // Next mask and filtered output from the current samples.
  always_comb begin
    w_mask_nx = MASK_ALL;
    w_dir_nx  = r_s1;
    if (!i_dis) begin
      unique case (i_mode)
        JM_PASS: w_dir_nx = r_s1;
        JM_SOCD: w_dir_nx = socd4(r_s1);
        JM_NEWEST: begin
          if (i_mode_chg)
            w_mask_nx = MASK_ALL;
          else if (w_new != 4'b0)
            w_mask_nx = prio4(w_new);
          else if ((r_s1 & r_mask) == 4'b0)
            w_mask_nx = MASK_ALL;
          else if (r_mask == MASK_ALL && r_s1 != 4'b0)
            w_mask_nx = prio4(r_s1);
          else
            w_mask_nx = r_mask;
          w_dir_nx = prio4(r_s1 & w_mask_nx);
        end
        JM_FIRST: begin
          if (i_mode_chg)
            w_mask_nx = MASK_ALL;
          else if ((r_s1 & r_mask) == 4'b0)
            w_mask_nx = (r_s1 != 4'b0) ? prio4(r_s1) : MASK_ALL;
          else if (r_mask == MASK_ALL && r_s1 != 4'b0)
            w_mask_nx = prio4(r_s1);
          else
            w_mask_nx = r_mask;
          w_dir_nx = prio4(r_s1 & w_mask_nx);
        end
      endcase
    end
  end

  // Sample pipeline, mask and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_mask <= MASK_ALL;
      r_dir  <= '0;
      r_chg  <= 1'b0;
    end else begin
      r_s1   <= w_acc;
      r_s2   <= r_s1;
      r_mask <= w_mask_nx;
      r_dir  <= w_dir_nx;
      r_chg  <= (w_dir_nx != r_dir);
    end
  end

  assign o_dir = r_dir;
  assign o_chg = r_chg;

endmodule

// File: rtl/joy_dir_filter.sv
// joy_dir_filter: N-player joystick direction filter (pass/newest/first/SOCD).
// Build option: JOY_DEBOUNCE_EN enables per-bit debouncing in every lane.
module joy_dir_filter
  import joy_dir_pkg::*;
#(
  parameter int PLAYERS         = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   dis,
  input  logic [4*PLAYERS-1:0]   indir,
  output logic [4*PLAYERS-1:0]   outdir,
  output logic [PLAYERS-1:0]     dir_chg
);

  if (PLAYERS < 1 || PLAYERS > 4) begin : g_bad_players
    $error("PLAYERS out of range");
  end

  logic [1:0] r_mode_q;
  logic       w_mode_chg;
  joy_mode_t  w_mode;

  assign w_mode     = joy_mode_t'(mode);
  assign w_mode_chg = (mode != r_mode_q);

  // Remember last cycle's mode to spot run-time mode switches.
  always_ff @(posedge clk) begin
    if (reset) r_mode_q <= 2'd0;
    else       r_mode_q <= mode;
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_lane
    joy_dir_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_mode    (w_mode),
      .i_mode_chg(w_mode_chg),
      .i_dis     (dis),
      .i_dir     (indir[4*p +: 4]),
      .o_dir     (outdir[4*p +: 4]),
      .o_chg     (dir_chg[p])
    );
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// tb_joy_dir_filter: directed stimulus with a selection-based reference model.
// Build option: JOY_DEBOUNCE_EN adds debounce-specific checks.
module tb_joy_dir_filter;
  import joy_dir_pkg::*;

  localparam int P  = 2;
  localparam int DB = 4;
`ifdef JOY_DEBOUNCE_EN
  localparam int L = DB + 2;
`else
  localparam int L = 2;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           dis = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [4*P-1:0] indir = '0;
  logic [4*P-1:0] outdir;
  logic [P-1:0]   dir_chg;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  always #5 clk = ~clk;

  joy_dir_filter #(
    .PLAYERS(P),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .dis    (dis),
    .indir  (indir),
    .outdir (outdir),
    .dir_chg(dir_chg)
  );

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  function automatic int topbit(input logic [3:0] x);
    for (int i = 3; i >= 0; i--) if (x[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // Reference model: each lane tracks which direction it has chosen
  // (-1 = none chosen, any held direction may show).
  logic [3:0] m_s1 [P];
  logic [3:0] m_s2 [P];
  logic [3:0] m_out[P];
  logic       m_chg[P];
  int         m_sel[P];
  logic [1:0] m_modeq;
`ifdef JOY_DEBOUNCE_EN
  logic [3:0] m_acc[P];
  int         m_run[P][4];
`endif

  always @(posedge clk) begin : model
    logic [3:0] held, fresh, nxt, smp;
    edges++;
    for (int p = 0; p < P; p++) begin
      if (reset) begin
        m_s1[p] = '0; m_s2[p] = '0; m_out[p] = '0;
        m_chg[p] = 1'b0; m_sel[p] = -1;
`ifdef JOY_DEBOUNCE_EN
        m_acc[p] = '0;
        for (int b = 0; b < 4; b++) m_run[p][b] = 0;
`endif
      end else begin
        held  = m_s1[p];
        fresh = held & ~m_s2[p];
        if (dis || mode == JM_PASS) begin
          m_sel[p] = -1; nxt = held;
        end else if (mode == JM_SOCD) begin
          m_sel[p] = -1;
          nxt = held;
          if (held[3] && held[2]) nxt[3:2] = 2'b00;
          if (held[1] && held[0]) nxt[1:0] = 2'b00;
        end else if (mode != m_modeq) begin
          m_sel[p] = -1; nxt = onehot(topbit(held));
        end else if (mode == JM_NEWEST) begin
          if (fresh != 0) m_sel[p] = topbit(fresh);
          else if (m_sel[p] >= 0 && !held[m_sel[p]]) m_sel[p] = -1;
          nxt = (m_sel[p] >= 0) ? onehot(m_sel[p])
                                : onehot(topbit(held));
        end else begin
          if (m_sel[p] < 0 || !held[m_sel[p]]) m_sel[p] = topbit(held);
          nxt = onehot(m_sel[p]);
        end
        m_chg[p] = (nxt != m_out[p]);
        m_out[p] = nxt;
        m_s2[p]  = m_s1[p];
`ifdef JOY_DEBOUNCE_EN
        smp = m_acc[p];
        for (int b = 0; b < 4; b++) begin
          if (indir[4*p+b] == m_acc[p][b]) m_run[p][b] = 0;
          else begin
            m_run[p][b]++;
            if (m_run[p][b] == DB) begin
              m_acc[p][b] = indir[4*p+b];
              m_run[p][b] = 0;
            end
          end
        end
`else
        smp = indir[4*p +: 4];
`endif
        m_s1[p] = smp;
      end
    end
    m_modeq = reset ? 2'd0 : mode;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (edges > 0) begin
      for (int p = 0; p < P; p++) begin
        chk($sformatf("model_out_p%0d", p), 8'(outdir[4*p +: 4]),
            8'(m_out[p]));
        chk($sformatf("model_chg_p%0d", p), 8'(dir_chg[p]),
            8'(m_chg[p]));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [3:0] p0, input logic [3:0] p1);
    indir = {p1, p0};
  endtask

  task automatic lit(input string nm, input int p, input logic [3:0] e);
    chk(nm, 8'(outdir[4*p +: 4]), 8'(e));
  endtask

  logic [3:0] socd_in [4];
  logic [3:0] socd_ex [4];

  initial begin
    socd_in[0] = 4'b1111; socd_ex[0] = 4'b0000;
    socd_in[1] = 4'b1001; socd_ex[1] = 4'b1001;
    socd_in[2] = 4'b1100; socd_ex[2] = 4'b0000;
    socd_in[3] = 4'b1110; socd_ex[3] = 4'b0010;

    reset = 1'b1; mode = JM_PASS; put(4'b0, 4'b0);
    step(2);
    lit("rst_out", 0, 4'b0000);
    chk("rst_chg", 8'(dir_chg), 8'd0);

    reset = 1'b0; mode = JM_NEWEST;
    step(2);
    put(4'b0001, 4'b0000); step(L);
    lit("new_r", 0, 4'b0001);
    chk("new_r_chg", 8'(dir_chg[0]), 8'd1);
    step(1);
    chk("new_r_pulse", 8'(dir_chg[0]), 8'd0);
    put(4'b1001, 4'b0000); step(L);
    lit("new_u", 0, 4'b1000);
    chk("new_u_chg", 8'(dir_chg[0]), 8'd1);
    put(4'b0001, 4'b0000); step(L);
    lit("new_rel_u", 0, 4'b0001);
    put(4'b0000, 4'b0000); step(L + 1);
    put(4'b0110, 4'b0000); step(L);
    lit("new_ld", 0, 4'b0100);
    put(4'b0010, 4'b0000); step(L);
    lit("new_rel_d", 0, 4'b0010);
    put(4'b0000, 4'b0000); step(L + 1);

    mode = JM_FIRST;
    put(4'b0001, 4'b0011); step(L);
    lit("first_r", 0, 4'b0001);
    lit("first_p1", 1, 4'b0010);
    put(4'b1001, 4'b0011); step(L);
    lit("first_keep", 0, 4'b0001);
    put(4'b1000, 4'b0011); step(L);
    lit("first_rel_r", 0, 4'b1000);
    put(4'b0000, 4'b0000); step(L + 1);

    mode = JM_SOCD;
    for (int i = 0; i < 4; i++) begin
      put(socd_in[i], socd_in[3 - i]); step(L);
      lit($sformatf("socd_%0d", i), 0, socd_ex[i]);
    end

    mode = JM_NEWEST;
    put(4'b1010, 4'b0000); step(L + 1);
    lit("sw_newest", 0, 4'b1000);
    mode = JM_PASS; step(2);
    lit("sw_pass", 0, 4'b1010);

    reset = 1'b1; step(1);
    lit("mid_rst", 0, 4'b0000);
    chk("mid_rst_chg", 8'(dir_chg), 8'd0);
    reset = 1'b0;

    mode = JM_NEWEST; dis = 1'b1;
    put(4'b0101, 4'b0000); step(L);
    lit("dis", 0, 4'b0101);
    dis = 1'b0; step(2);
    lit("dis_off", 0, 4'b0100);

`ifdef JOY_DEBOUNCE_EN
    mode = JM_PASS;
    put(4'b0000, 4'b0000); step(L + 1);
    put(4'b0001, 4'b0000); step(2);
    put(4'b0000, 4'b0000); step(L + 2);
    lit("db_glitch", 0, 4'b0000);
    put(4'b0001, 4'b0000); step(L - 1);
    lit("db_early", 0, 4'b0000);
    step(1);
    lit("db_hold", 0, 4'b0001);
    lit("db_p1", 1, 4'b0000);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
